// File: rtl/ps2_key_queue.sv
// ps2_key_queue: samples the translator's one-hot key byte, validates it,
// queues accepted keys in a small FIFO and serves data/status/commands on
// the PicoBlaze-style port bus.
// Optional interrupt state machine: define PS2_KEYQ_INTERRUPT_EN to build it;
// otherwise interrupt is tied low and software polls the status port.
module ps2_key_queue #(
    parameter int          DEPTH   = 4,
    parameter logic [7:0]  DATA_ID = 8'h03,
    parameter logic [7:0]  STAT_ID = 8'h02,
    parameter logic [7:0]  CMD_ID  = 8'h04
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [7:0] key_dec,
    output logic       key_ack,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    input  logic       write_strobe,
    input  logic [7:0] out_port,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [7:0]    key_q, key_d, key_p_q, key_p_d;
    logic          key_ack_q, key_ack_d;
    logic [7:0]    in_port_q, in_port_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, inv_q, inv_d;
    logic [7:0]    mem_q [DEPTH];

    logic       ev, legal, flush, clr, empty, full, pop, pop_eff, push;
    logic       ovf_set, inv_set;
    logic [31:0] cnt32;
    logic [3:0] cnt4;
    logic [7:0] status, head;

    // Event detection, FIFO bookkeeping, sticky flags and the read-data mux
    always_comb begin
        key_d    = key_dec;
        key_p_d  = key_q;
        ev       = (key_q != 8'h00) && (key_q != key_p_q);
        legal    = (key_q[7:6] == 2'b00) && $onehot(key_q[5:0]);
        flush    = write_strobe && (port_id == CMD_ID) && out_port[0];
        clr      = write_strobe && (port_id == CMD_ID) && out_port[1];
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        pop      = read_strobe && (port_id == DATA_ID) && !empty;
        // Pop on a full queue frees the slot for a same-cycle push; flush beats both
        push     = ev && legal && (!full || pop) && !flush;
        pop_eff  = pop && !flush;
        ovf_set  = ev && legal && full && !pop && !flush;
        inv_set  = ev && !legal;
        key_ack_d = ev;

        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push)    wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_eff) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop_eff})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // A set in the same cycle as a clear wins
        ovf_d = (ovf_q & ~clr) | ovf_set;
        inv_d = (inv_q & ~clr) | inv_set;

        cnt32  = 32'(count_q);
        cnt4   = (cnt32 > 32'd15) ? 4'hF : cnt32[3:0];
        status = {ovf_q, inv_q, full, empty, cnt4};
        head   = mem_q[rd_ptr_q];

        if (port_id == DATA_ID)      in_port_d = empty ? 8'h00 : head;
        else if (port_id == STAT_ID) in_port_d = status;
        else                         in_port_d = 8'h00;
    end

    // Control/state registers, cleared by the asynchronous reset
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            key_q     <= 8'h00;
            key_p_q   <= 8'h00;
            key_ack_q <= 1'b0;
            in_port_q <= 8'h00;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            key_q     <= key_d;
            key_p_q   <= key_p_d;
            key_ack_q <= key_ack_d;
            in_port_q <= in_port_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            inv_q     <= inv_d;
        end
    end

    // FIFO storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= key_q;
    end

    assign key_ack = key_ack_q;
    assign in_port = in_port_q;

`ifdef PS2_KEYQ_INTERRUPT_EN
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} irq_state_t;
    irq_state_t irq_state_q;
    logic       irq_q;

    // Interrupt FSM: request while keys are waiting, re-arm on drain or new key
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            irq_state_q <= S_IDLE;
            irq_q       <= 1'b0;
        end else if (flush) begin
            irq_state_q <= S_IDLE;
            irq_q       <= 1'b0;
        end else begin
            case (irq_state_q)
                S_IDLE: if (!empty) begin
                    irq_state_q <= S_REQ;
                    irq_q       <= 1'b1;
                end
                S_REQ: if (interrupt_ack) begin
                    irq_state_q <= S_WAIT;
                    irq_q       <= 1'b0;
                end
                S_WAIT: if (empty || push) begin
                    irq_state_q <= S_IDLE;
                    irq_q       <= 1'b0;
                end
                default: begin
                    irq_state_q <= S_IDLE;
                    irq_q       <= 1'b0;
                end
            endcase
        end
    end

    assign interrupt = irq_q;
`else
    logic unused_irq_ack;
    assign unused_irq_ack = interrupt_ack;
    assign interrupt      = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_key_queue.sv
// Scoreboarded bench for ps2_key_queue: a queue-based reference model
// predicts every read value; a monitor compares in_port after each read.
module tb_ps2_key_queue;
    localparam int         DEPTH   = 4;
    localparam logic [7:0] DATA_ID = 8'h03;
    localparam logic [7:0] STAT_ID = 8'h02;
    localparam logic [7:0] CMD_ID  = 8'h04;

    logic       clk = 1'b0;
    logic       RST;
    logic [7:0] key_dec, port_id, out_port, in_port;
    logic       key_ack, read_strobe, write_strobe, interrupt, interrupt_ack;

    ps2_key_queue #(.DEPTH(DEPTH), .DATA_ID(DATA_ID), .STAT_ID(STAT_ID), .CMD_ID(CMD_ID)) dut (
        .clk(clk), .RST(RST), .key_dec(key_dec), .key_ack(key_ack),
        .port_id(port_id), .read_strobe(read_strobe), .write_strobe(write_strobe),
        .out_port(out_port), .in_port(in_port), .interrupt(interrupt),
        .interrupt_ack(interrupt_ack)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mq[$];
    bit         m_ovf = 0, m_inv = 0;
    logic [7:0] m_last = 8'h00;
    int         m_evcnt = 0;

    function automatic logic [7:0] m_status();
        int n = mq.size();
        logic [3:0] c = (n > 15) ? 4'd15 : 4'(n);
        return {m_ovf, m_inv, (n == DEPTH), (n == 0), c};
    endfunction

    // A held key value produces an event only when it is non-zero and differs
    // from the previously held value.
    function automatic void m_event(input logic [7:0] v);
        if (v != 8'h00 && v != m_last) begin
            m_evcnt++;
            if ($countones(v) == 1 && v[7:6] == 2'b00) begin
                if (mq.size() < DEPTH) mq.push_back(v);
                else m_ovf = 1;
            end else begin
                m_inv = 1;
            end
        end
        m_last = v;
    endfunction

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    string      tag_q[$];
    logic       chk_q = 1'b0;
    int         ack_cnt = 0;

    always @(posedge clk) chk_q <= read_strobe;

    always @(negedge clk) begin
        if (key_ack) ack_cnt++;
        if (chk_q) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: read seen with no expectation, in_port=%0h", in_port);
            end else begin
                check(tag_q.pop_front(), 32'(in_port), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic key(input logic [7:0] v);
        key_dec = v;
        m_event(v);
        repeat (3) @(negedge clk);
    endtask

    task automatic rd(input logic [7:0] id, input string tag);
        logic [7:0] e;
        if (id == DATA_ID)      e = (mq.size() != 0) ? mq.pop_front() : 8'h00;
        else if (id == STAT_ID) e = m_status();
        else                    e = 8'h00;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        port_id     = id;
        read_strobe = 1'b1;
        @(negedge clk);
        read_strobe = 1'b0;
        port_id     = 8'h00;
    endtask

    task automatic cmd(input logic [1:0] b);
        if (b[0]) mq.delete();
        if (b[1]) begin m_ovf = 0; m_inv = 0; end
        port_id      = CMD_ID;
        out_port     = {6'b0, b};
        write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
        port_id      = 8'h00;
        out_port     = 8'h00;
    endtask

    // Key event whose push lands on the same edge as a DATA pop
    task automatic key_pop(input logic [7:0] v, input string tag);
        logic [7:0] e;
        key_dec = v;
        @(negedge clk);
        e = (mq.size() != 0) ? mq.pop_front() : 8'h00;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        m_event(v);
        port_id     = DATA_ID;
        read_strobe = 1'b1;
        @(negedge clk);
        read_strobe = 1'b0;
        port_id     = 8'h00;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        RST = 1'b1; key_dec = 8'h00; port_id = 8'h00; out_port = 8'h00;
        read_strobe = 1'b0; write_strobe = 1'b0; interrupt_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_port", 32'(in_port), 32'h00);
        check("rst_key_ack", 32'(key_ack), 32'h0);
        check("rst_interrupt", 32'(interrupt), 32'h0);
        RST = 1'b0;
        @(negedge clk);
        rd(STAT_ID, "rst_status");

        // single held key: one ack, at the second edge
        key_dec = 8'h20;
        m_event(8'h20);
        @(negedge clk); check("ack_edge1", 32'(key_ack), 32'h0);
        @(negedge clk); check("ack_edge2", 32'(key_ack), 32'h1);
        @(negedge clk); check("ack_edge3", 32'(key_ack), 32'h0);
        repeat (7) @(negedge clk);
        key(8'h00);
        check("ack_once", 32'(ack_cnt), 32'd1);
        rd(STAT_ID, "stat_one");
        rd(DATA_ID, "data_20");
        rd(STAT_ID, "stat_empty");

        // overflow on the fifth key
        key(8'h10); key(8'h08); key(8'h04); key(8'h02); key(8'h01);
        rd(STAT_ID, "stat_ovf_full");
        for (int i = 0; i < 5; i++) rd(DATA_ID, "data_drain");

        // invalid keys, then flag clear
        cmd(2'b10);
        a0 = ack_cnt;
        key(8'h30); key(8'h40);
        check("ack_invalid_pair", 32'(ack_cnt - a0), 32'd2);
        rd(STAT_ID, "stat_inv");
        cmd(2'b10);
        rd(STAT_ID, "stat_cleared");

        // full queue, simultaneous pop and push
        key(8'h01); key(8'h02); key(8'h04); key(8'h08);
        key_pop(8'h10, "pop_push_full");
        rd(STAT_ID, "stat_after_pp");
        for (int i = 0; i < 4; i++) rd(DATA_ID, "data_after_pp");
        key_pop(8'h20, "pop_push_empty");
        rd(STAT_ID, "stat_pp_empty");
        rd(DATA_ID, "data_pp_empty");

`ifdef PS2_KEYQ_INTERRUPT_EN
        key(8'h01);
        check("irq_set", 32'(interrupt), 32'h1);
        interrupt_ack = 1'b1; @(negedge clk); interrupt_ack = 1'b0;
        check("irq_acked", 32'(interrupt), 32'h0);
        rd(DATA_ID, "irq_pop");
        @(negedge clk);
        check("irq_idle_empty", 32'(interrupt), 32'h0);
        key(8'h02);
        check("irq_reassert", 32'(interrupt), 32'h1);
        cmd(2'b01);
        check("irq_flush", 32'(interrupt), 32'h0);
        rd(STAT_ID, "irq_stat_flush");
`else
        key(8'h01);
        check("irq_off_pending", 32'(interrupt), 32'h0);
        interrupt_ack = 1'b1; @(negedge clk); interrupt_ack = 1'b0;
        check("irq_off_ack", 32'(interrupt), 32'h0);
        cmd(2'b01);
        rd(STAT_ID, "stat_flush");
`endif

        // asynchronous reset in the middle of a push
        key(8'h00);
        key(8'h01); key(8'h02); key(8'h04);
        port_id = STAT_ID;
        key_dec = 8'h08;
        @(posedge clk); @(posedge clk);
        #2 RST = 1'b1;
        #1;
        check("async_in_port", 32'(in_port), 32'h00);
        check("async_key_ack", 32'(key_ack), 32'h0);
        check("async_interrupt", 32'(interrupt), 32'h0);
        key_dec = 8'h00; port_id = 8'h00;
        mq.delete(); m_ovf = 0; m_inv = 0; m_last = 8'h00;
        @(negedge clk);
        RST = 1'b0;
        @(negedge clk);
        rd(STAT_ID, "stat_post_reset");

        // randomized traffic
        for (int it = 0; it < 200; it++) begin
            int op = $urandom_range(0, 9);
            logic [7:0] v;
            int r = $urandom_range(0, 9);
            if (r < 6)       v = 8'(1 << $urandom_range(0, 5));
            else if (r == 6) v = 8'h00;
            else if (r == 7) v = 8'($urandom);
            else if (r == 8) v = m_last;
            else             v = 8'(1 << $urandom_range(6, 7));
            case (op)
                0, 1, 2, 3: key(v);
                4, 5:       rd(DATA_ID, "rnd_data");
                6:          rd(STAT_ID, "rnd_stat");
                7:          rd(8'h80 | 8'($urandom_range(0, 127)), "rnd_unmapped");
                8:          cmd(2'($urandom_range(0, 3)));
                default:    key_pop(v, "rnd_key_pop");
            endcase
        end
        rd(STAT_ID, "final_stat");
        repeat (3) @(negedge clk);
        check("ack_total", 32'(ack_cnt), 32'(m_evcnt));
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
